// File: rtl/uart_tx_sched.sv
// Byte scheduler feeding the UART TX: round-robin between a 16-bit ALU result
// (two bytes, LSB first) and an 8-bit register-file result, paced by tx_busy.
module uart_tx_sched #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_vld,
    input  logic [2*DATA_W-1:0] alu_data,
    output logic                alu_rdy,
    input  logic                rf_vld,
    input  logic [DATA_W-1:0]   rf_data,
    output logic                rf_rdy,
    input  logic                tx_busy,
    output logic                tx_data_valid,
    output logic [DATA_W-1:0]   tx_p_data,
    output logic                sched_busy
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;

    localparam logic GRANT_RF  = 1'b0;
    localparam logic GRANT_ALU = 1'b1;

    state_t              state, state_nxt;
    logic [2*DATA_W-1:0] hold;
    logic [1:0]          bytes_left;
    logic                last_grant;
    logic                grant_alu, grant_rf;

    // Grants are masked during reset so a request held across reset is not
    // acknowledged until reset is released.
    always_comb begin
        state_nxt = state;
        grant_alu = 1'b0;
        grant_rf  = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    grant_alu = alu_vld & (~rf_vld | (last_grant == GRANT_RF));
                    grant_rf  = rf_vld & ~grant_alu;
                    if (grant_alu | grant_rf)
                        state_nxt = LOAD;
                end
            end
            LOAD:    state_nxt = WAIT_HI;
            WAIT_HI: if (tx_busy) state_nxt = WAIT_LO;
            WAIT_LO: if (!tx_busy) state_nxt = (bytes_left == 2'd1) ? IDLE : LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sched_busy <= 1'b0;
            hold       <= '0;
            bytes_left <= 2'd0;
            last_grant <= GRANT_RF;
        end else begin
            state      <= state_nxt;
            sched_busy <= (state_nxt != IDLE);
            if (grant_alu) begin
                hold       <= alu_data;
                bytes_left <= 2'd2;
                last_grant <= GRANT_ALU;
            end else if (grant_rf) begin
                hold       <= {{DATA_W{1'b0}}, rf_data};
                bytes_left <= 2'd1;
                last_grant <= GRANT_RF;
            end else if (state == WAIT_LO && !tx_busy) begin
                bytes_left <= bytes_left - 2'd1;
                if (bytes_left != 2'd1)
                    hold <= hold >> DATA_W;
            end
        end
    end

    assign alu_rdy       = grant_alu;
    assign rf_rdy        = grant_rf;
    assign tx_data_valid = (state == LOAD);
    assign tx_p_data     = hold[DATA_W-1:0];

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized scoreboard bench for uart_tx_sched with a behavioural UART TX
// responder and a transaction-level round-robin reference model.
module tb_uart_tx_sched;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alu_vld = 1'b0;
    logic [2*DW-1:0] alu_data = '0;
    logic          alu_rdy;
    logic          rf_vld = 1'b0;
    logic [DW-1:0] rf_data = '0;
    logic          rf_rdy;
    logic          tx_busy = 1'b0;
    logic          tx_data_valid;
    logic [DW-1:0] tx_p_data;
    logic          sched_busy;

    uart_tx_sched #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .alu_vld(alu_vld), .alu_data(alu_data), .alu_rdy(alu_rdy),
        .rf_vld(rf_vld), .rf_data(rf_data), .rf_rdy(rf_rdy),
        .tx_busy(tx_busy), .tx_data_valid(tx_data_valid),
        .tx_p_data(tx_p_data), .sched_busy(sched_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] b;
        bit            second;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;
    bit   auto_tx = 1'b0;
    int   force_d = 0;
    bit   model_last_alu = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_alu(input logic [2*DW-1:0] d);
        expq.push_back('{d[DW-1:0], 1'b0});
        expq.push_back('{d[2*DW-1:DW], 1'b1});
    endtask

    task automatic push_rf(input logic [DW-1:0] d);
        expq.push_back('{d, 1'b0});
    endtask

    // UART TX responder and scoreboard monitor: every pulse pops one expected byte.
    initial begin : monitor
        exp_t          e;
        logic [DW-1:0] b;
        int            d, l;
        bit            have;
        have = 1'b0;
        forever begin
            if (!have) @(negedge clk);
            have = 1'b0;
            if (auto_tx && tx_data_valid) begin
                b = tx_p_data;
                if (expq.size() == 0) check("extra_pulse", 32'd1, 32'd0);
                else begin
                    e = expq.pop_front();
                    check("tx_byte", 32'(b), 32'(e.b));
                end
                d = (force_d != 0) ? force_d : $urandom_range(1, 4);
                l = $urandom_range(1, 6);
                for (int i = 1; i <= d + l; i++) begin
                    @(posedge clk); #1;
                    tx_busy = (i >= d) && (i < d + l);
                    @(negedge clk);
                    check("one_pulse", 32'(tx_data_valid), 32'd0);
                    check("data_hold", 32'(tx_p_data), 32'(b));
                end
                @(negedge clk);
                check("byte_gap", 32'(tx_data_valid),
                      32'((expq.size() > 0) && expq[0].second));
                have = 1'b1;
            end
        end
    end

    // Issue requests; rf_late > 0 raises rf_vld that many cycles after the ALU accept.
    // Caller is always positioned just after a rising edge.
    task automatic do_req(input bit a, input bit r, input logic [2*DW-1:0] ad,
                          input logic [DW-1:0] rd, input int rf_late);
        int  n, cnt;
        bit  ra, rr, rf_pending;
        if (a && r && rf_late == 0) begin
            if (!model_last_alu) begin push_alu(ad); push_rf(rd); end
            else begin push_rf(rd); push_alu(ad); end
        end else begin
            if (a) push_alu(ad);
            if (r) push_rf(rd);
            model_last_alu = !r;
        end
        alu_data   = ad;
        rf_data    = rd;
        alu_vld    = a;
        rf_vld     = r && (rf_late == 0);
        rf_pending = r && (rf_late != 0);
        cnt = -1;
        n = 0;
        while ((alu_vld || rf_vld || rf_pending) && n < 2000) begin
            @(negedge clk);
            n++;
            if (alu_rdy || rf_rdy) begin
                check("rdy_onehot", 32'(alu_rdy && rf_rdy), 32'd0);
                check("rdy_in_idle", 32'(sched_busy), 32'd0);
                check("rdy_needs_vld", 32'((alu_rdy && !alu_vld) || (rf_rdy && !rf_vld)), 32'd0);
            end
            ra = alu_rdy && alu_vld;
            rr = rf_rdy && rf_vld;
            @(posedge clk); #1;
            if (ra) begin
                alu_vld  = 1'b0;
                alu_data = 16'($urandom);
                if (rf_pending) cnt = rf_late;
            end
            if (rr) begin
                rf_vld  = 1'b0;
                rf_data = 8'($urandom);
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    rf_vld     = 1'b1;
                    rf_pending = 1'b0;
                    cnt        = -1;
                end
            end
        end
        if (n >= 2000) check("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((expq.size() != 0 || sched_busy) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 32'(expq.size()), 32'd0);
    endtask

    initial begin : wdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int pat, g;
        // Reset with an ALU request already pending: nothing may be acknowledged.
        alu_vld  = 1'b1;
        alu_data = 16'h1234;
        @(negedge clk);
        check("rst_alu_rdy", 32'(alu_rdy), 32'd0);
        check("rst_rf_rdy", 32'(rf_rdy), 32'd0);
        check("rst_txv", 32'(tx_data_valid), 32'd0);
        check("rst_sbusy", 32'(sched_busy), 32'd0);
        check("rst_pdata", 32'(tx_p_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("grant_after_rst", 32'(alu_rdy), 32'd1);
        @(posedge clk); #1;
        alu_vld = 1'b0;
        @(negedge clk);
        check("load_pulse", 32'(tx_data_valid), 32'd1);
        check("load_byte", 32'(tx_p_data), 32'h34);
        check("load_sbusy", 32'(sched_busy), 32'd1);
        @(posedge clk); #1;
        tx_busy = 1'b1;
        @(posedge clk); #1;
        // In WAIT_LO of the first ALU byte: abort with the request re-presented.
        alu_vld = 1'b1;
        rst = 1'b1;
        #1;
        check("abort_txv", 32'(tx_data_valid), 32'd0);
        check("abort_sbusy", 32'(sched_busy), 32'd0);
        check("abort_pdata", 32'(tx_p_data), 32'd0);
        check("abort_alu_rdy", 32'(alu_rdy), 32'd0);
        tx_busy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_last_alu = 1'b0;
        auto_tx = 1'b1;
        do_req(1'b1, 1'b0, 16'h1234, 8'h00, 0);
        wait_done();

        do_req(1'b0, 1'b1, 16'h0000, 8'hA5, 0);
        wait_done();

        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, 1'b1, 16'($urandom), 8'($urandom), 0);
            wait_done();
        end

        do_req(1'b1, 1'b1, 16'hBEEF, 8'h5A, 3);
        wait_done();

        force_d = 5;
        do_req(1'b1, 1'b0, 16'hC0DE, 8'h00, 0);
        wait_done();
        force_d = 0;

        for (int i = 0; i < 40; i++) begin
            pat = $urandom_range(0, 3);
            case (pat)
                0: do_req(1'b1, 1'b0, 16'($urandom), 8'($urandom), 0);
                1: do_req(1'b0, 1'b1, 16'($urandom), 8'($urandom), 0);
                2: do_req(1'b1, 1'b1, 16'($urandom), 8'($urandom), 0);
                default: do_req(1'b1, 1'b1, 16'($urandom), 8'($urandom), $urandom_range(1, 4));
            endcase
            g = $urandom_range(0, 3);
            if (g == 3) wait_done();
            else repeat (g) begin @(posedge clk); #1; end
        end
        wait_done();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
